// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: three masters (fetch, load, store) share one slave bus.
// Ports: i_clk/i_reset, per-master i_mN_* request, o_mN_ack/err, shared o_m_dat,
//   slave bus o_wb_*/i_wb_*, o_grant (3 = none), o_timeout pulse.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic [31:0] i_m0_addr,
  input  logic        i_m0_cyc,
  input  logic [3:0]  i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_dat,
  output logic        o_m0_ack,
  output logic        o_m0_err,

  input  logic [31:0] i_m1_addr,
  input  logic        i_m1_cyc,
  input  logic [3:0]  i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_dat,
  output logic        o_m1_ack,
  output logic        o_m1_err,

  input  logic [31:0] i_m2_addr,
  input  logic        i_m2_cyc,
  input  logic [3:0]  i_m2_stb,
  input  logic        i_m2_we,
  input  logic [31:0] i_m2_dat,
  output logic        o_m2_ack,
  output logic        o_m2_err,

  output logic [31:0] o_m_dat,

  output logic [31:0] o_wb_addr,
  output logic        o_wb_cyc,
  output logic [3:0]  o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,

  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] NONE     = 2'd3;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q,  last_d;
  logic [7:0]  cnt_q,   cnt_d;

  logic [2:0]  req;
  logic [1:0]  pick;
  logic        busy;
  logic        tmo;
  logic        resp;

  logic [31:0] g_addr;
  logic        g_cyc;
  logic [3:0]  g_stb;
  logic        g_we;
  logic [31:0] g_dat;

  assign req  = {i_m2_cyc, i_m1_cyc, i_m0_cyc};
  assign busy = (state_q == BUSY);
  assign resp = i_wb_ack | i_wb_err;

  // Round-robin search starting at the master after the last one served.
  always_comb begin
    pick = NONE;
    unique case (last_q)
      2'd0: begin
        if      (req[1]) pick = 2'd1;
        else if (req[2]) pick = 2'd2;
        else if (req[0]) pick = 2'd0;
      end
      2'd1: begin
        if      (req[2]) pick = 2'd2;
        else if (req[0]) pick = 2'd0;
        else if (req[1]) pick = 2'd1;
      end
      default: begin
        if      (req[0]) pick = 2'd0;
        else if (req[1]) pick = 2'd1;
        else if (req[2]) pick = 2'd2;
      end
    endcase
  end

  // Granted master's request fields.
  always_comb begin
    g_addr = '0;
    g_cyc  = 1'b0;
    g_stb  = '0;
    g_we   = 1'b0;
    g_dat  = '0;
    unique case (1'b1)
      (grant_q == 2'd0): begin
        g_addr = i_m0_addr;
        g_cyc  = i_m0_cyc;
        g_stb  = i_m0_stb;
        g_we   = i_m0_we;
        g_dat  = i_m0_dat;
      end
      (grant_q == 2'd1): begin
        g_addr = i_m1_addr;
        g_cyc  = i_m1_cyc;
        g_stb  = i_m1_stb;
        g_we   = i_m1_we;
        g_dat  = i_m1_dat;
      end
      (grant_q == 2'd2): begin
        g_addr = i_m2_addr;
        g_cyc  = i_m2_cyc;
        g_stb  = i_m2_stb;
        g_we   = i_m2_we;
        g_dat  = i_m2_dat;
      end
      default: begin
        g_addr = '0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          grant_d = pick;
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (resp) begin
          state_d = IDLE;
          grant_d = NONE;
        end else if (!g_cyc) begin
          // Master abandoned its cycle.
          state_d = IDLE;
          grant_d = NONE;
        end else if (cnt_q == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = IDLE;
          grant_d = NONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= NONE;
      last_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_wb_addr = busy ? g_addr : '0;
  assign o_wb_cyc  = busy & g_cyc;
  assign o_wb_stb  = busy ? g_stb : '0;
  assign o_wb_we   = busy & g_we;
  assign o_wb_dat  = busy ? g_dat : '0;

  assign o_m_dat   = i_wb_dat;
  assign o_grant   = grant_q;
  assign o_timeout = tmo;

  // Forced timeout error rides on the same per-master error line.
  assign o_m0_ack = busy & (grant_q == 2'd0) & i_wb_ack;
  assign o_m1_ack = busy & (grant_q == 2'd1) & i_wb_ack;
  assign o_m2_ack = busy & (grant_q == 2'd2) & i_wb_ack;
  assign o_m0_err = busy & (grant_q == 2'd0) & (i_wb_err | tmo);
  assign o_m1_err = busy & (grant_q == 2'd1) & (i_wb_err | tmo);
  assign o_m2_err = busy & (grant_q == 2'd2) & (i_wb_err | tmo);

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: BUSY cycles without ack/err before the arbiter forces an error (legal 1..255).
REQ-002 SHALL have i_clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have i_reset  input  1  reset, synchronous, active-high; clock i_clk.
REQ-004 SHALL have, for each master n in {0 fetch, 1 load, 2 store}, i_mn_addr  input  32  word address (bits [1:0] zero).
REQ-005 SHALL have i_mn_cyc  input  1  bus request / cycle active, per master.
REQ-006 SHALL have i_mn_stb  input  4  byte-lane strobes, bit 3 = bits [31:24] (big-endian lanes), per master.
REQ-007 SHALL have i_mn_we  input  1  write enable, per master.
REQ-008 SHALL have i_mn_dat  input  32  write data, per master.
REQ-009 SHALL have o_mn_ack  output  1  ack routed to master n only.
REQ-010 SHALL have o_mn_err  output  1  error routed to master n only.
REQ-011 SHALL have o_m_dat  output  32  read data, i_wb_dat passed through to all masters.
REQ-012 SHALL have o_wb_addr/o_wb_cyc/o_wb_stb/o_wb_we/o_wb_dat  output  32/1/4/1/32  slave-side bus.
REQ-013 SHALL have i_wb_dat  input  32, i_wb_ack  input  1, i_wb_err  input  1  slave responses.
REQ-014 SHALL have o_grant  output  2  index of the granted master (3 = none).
REQ-015 SHALL have o_timeout  output  1  one-cycle pulse when a timeout error is forced.

Function
REQ-016 SHALL implement two states, IDLE and BUSY, plus a registered 2-bit grant and a 2-bit last-served pointer.
REQ-017 In IDLE, when any i_mn_cyc is high, the arbiter SHALL select one requester by round-robin, searching from (last+1) mod 3, register the grant, update last, and enter BUSY.
REQ-018 Grant latency SHALL be exactly one cycle: o_wb_cyc asserts the cycle after the request is sampled in IDLE.
REQ-019 In BUSY, o_wb_addr, o_wb_stb, o_wb_we and o_wb_dat SHALL be combinational copies of the granted master's inputs, and o_wb_cyc SHALL equal that master's i_mn_cyc.
REQ-020 In IDLE, o_wb_cyc, o_wb_stb and o_wb_we SHALL be 0; o_wb_addr and o_wb_dat SHALL be 0.
REQ-021 o_mn_ack/o_mn_err SHALL equal i_wb_ack/i_wb_err gated by (BUSY and grant==n), combinationally; non-granted masters see 0.
REQ-022 In BUSY, i_wb_ack or i_wb_err SHALL return the arbiter to IDLE on the next edge; back-to-back grant needs at least one IDLE cycle.
REQ-023 In BUSY, if the granted master drops i_mn_cyc without ack/err, the arbiter SHALL return to IDLE (abandoned cycle).
REQ-024 An 8-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack/err.
REQ-025 When the counter equals TIMEOUT-1 and no ack/err is present, the arbiter SHALL assert o_mn_err to the granted master and o_timeout for that cycle, then enter IDLE.
REQ-026 Simultaneous slave ack and err SHALL both be forwarded; the master resolves priority.
REQ-027 A master requesting in IDLE while another is granted SHALL wait; no request is dropped, and each master is served within 3 grants.

Reset
REQ-028 On i_reset the arbiter SHALL enter IDLE, set grant=3, last=2 (so master 0 wins first), and clear the counter; o_timeout=0.
REQ-029 Reset asserted mid-BUSY SHALL abort the cycle: o_wb_cyc=0 and all o_mn_ack/o_mn_err=0 in the following cycle.

Verification
REQ-030 Single load: m1 cyc, stb=4'b1000, addr=0x100; slave acks 2 cycles later with 0xAABBCCDD -> o_wb_cyc on cycle+1, o_m1_ack=1 with o_m_dat=0xAABBCCDD, o_m0_ack=0.
REQ-031 Contention after reset: m0, m1 and m2 assert cyc together, slave acks each after 1 cycle -> grant order 0,1,2, with one IDLE cycle between grants.
REQ-032 Fairness: m0 and m2 request continuously -> grants alternate 0,2,0,2.
REQ-033 Timeout: TIMEOUT=4, m2 write with no slave response -> o_m2_err and o_timeout high on the 4th BUSY cycle, then IDLE.
REQ-034 Slave error: i_wb_err on a load -> o_m1_err=1 for one cycle, o_m1_ack=0, and the next request is granted after one IDLE cycle.
REQ-035 Reset mid-cycle: i_reset during BUSY for m0 -> next cycle o_wb_cyc=0, o_grant=3; a subsequent m1 request is granted normally.
